// File: rtl/cnn_mem_pkg.sv
// Shared types and default widths for the CNN16 RAM port arbiter.
package cnn_mem_pkg;

   localparam int CNN_DATA_W = 16;
   localparam int CNN_ADDR_W = 12;

   typedef enum logic [1:0] {
      ST_CPU      = 2'd0,
      ST_DRAIN    = 2'd1,
      ST_LOAD     = 2'd2,
      ST_HANDBACK = 2'd3
   } arb_state_t;

endpackage

// File: rtl/cnn_rd_lat_tracker.sv
// Tracks CPU reads through the RAM pipeline: busy while any read is in flight,
// capture strobe on the cycle the RAM presents the data for the oldest read.
module cnn_rd_lat_tracker #(
   parameter int RD_LAT = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic rd_issue,
   output logic rd_busy,
   output logic rd_capture
);

   logic [RD_LAT-1:0] vld_r;

   // Valid shift register, one stage per RAM read-latency edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_r <= {RD_LAT{1'b0}};
      end else begin
         vld_r[0] <= rd_issue;
         for (int i = 1; i < RD_LAT; i++) begin
            vld_r[i] <= vld_r[i-1];
         end
      end
   end

   assign rd_busy    = |vld_r;
   assign rd_capture = vld_r[RD_LAT-1];

endmodule

// File: rtl/cnn_mem_port_arbiter.sv
// Single RAM port arbiter between the CPU and the program loader, with a drain-safe handover FSM.
// Define CNN_LOAD_AUTOINC_EN to address loader writes from load_count instead of ext_addr.
module cnn_mem_port_arbiter
   import cnn_mem_pkg::*;
#(
   parameter int DATA_W = CNN_DATA_W,
   parameter int ADDR_W = CNN_ADDR_W,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ext_sel,
   input  logic              ext_we,
   input  logic [ADDR_W-1:0] ext_addr,
   input  logic [DATA_W-1:0] ext_wdata,
   output logic              ext_grant,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_ready,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic [ADDR_W-1:0] load_count
);

   arb_state_t        state_r;
   arb_state_t        state_s;
   logic              accept_s;
   logic              wr_accept_s;
   logic              rd_accept_s;
   logic              rd_busy_s;
   logic              rd_capture_s;
   logic              cpu_ready_r;
   logic              ext_grant_r;
   logic [DATA_W-1:0] cpu_rdata_r;
   logic [ADDR_W-1:0] load_count_r;
   logic [ADDR_W-1:0] load_addr_s;
   logic [ADDR_W-1:0] addr_hold_r;
   logic [DATA_W-1:0] wdata_hold_r;
   logic              ram_we_s;
   logic [ADDR_W-1:0] ram_addr_s;
   logic [DATA_W-1:0] ram_wdata_s;

   // Loader request wins over a new CPU request; the ready cycle is never an accept cycle.
   assign accept_s    = !rst && (state_r == ST_CPU) && cpu_req && !rd_busy_s
                        && !cpu_ready_r && !ext_sel;
   assign wr_accept_s = accept_s & cpu_we;
   assign rd_accept_s = accept_s & ~cpu_we;

`ifdef CNN_LOAD_AUTOINC_EN
   assign load_addr_s = load_count_r;
`else
   assign load_addr_s = ext_addr;
`endif

   cnn_rd_lat_tracker #(
      .RD_LAT(RD_LAT)
   ) u_rd_lat_tracker (
      .clk       (clk),
      .rst       (rst),
      .rd_issue  (rd_accept_s),
      .rd_busy   (rd_busy_s),
      .rd_capture(rd_capture_s)
   );

   // Next-state logic and RAM port mux.
   always_comb begin
      state_s     = state_r;
      ram_we_s    = 1'b0;
      ram_addr_s  = addr_hold_r;
      ram_wdata_s = wdata_hold_r;

      case (state_r)
         ST_CPU: begin
            if (ext_sel) begin
               state_s = rd_busy_s ? ST_DRAIN : ST_LOAD;
            end else begin
               state_s = ST_CPU;
            end
         end
         ST_DRAIN: begin
            if (cpu_ready_r) begin
               state_s = ST_LOAD;
            end else begin
               state_s = ST_DRAIN;
            end
         end
         ST_LOAD: begin
            if (!ext_sel) begin
               state_s = ST_HANDBACK;
            end else begin
               state_s = ST_LOAD;
            end
         end
         ST_HANDBACK: state_s = ST_CPU;
         default:     state_s = ST_CPU;
      endcase

      if (state_r == ST_LOAD) begin
         ram_we_s    = ext_we;
         ram_addr_s  = load_addr_s;
         ram_wdata_s = ext_wdata;
      end else if (accept_s) begin
         ram_we_s    = cpu_we;
         ram_addr_s  = cpu_addr;
         ram_wdata_s = cpu_wdata;
      end else begin
         ram_we_s    = 1'b0;
         ram_addr_s  = addr_hold_r;
         ram_wdata_s = wdata_hold_r;
      end
   end

   // State register, handshake outputs, loader counter and RAM port hold registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r      <= ST_CPU;
         ext_grant_r  <= 1'b0;
         cpu_ready_r  <= 1'b0;
         cpu_rdata_r  <= {DATA_W{1'b0}};
         load_count_r <= {ADDR_W{1'b0}};
         addr_hold_r  <= {ADDR_W{1'b0}};
         wdata_hold_r <= {DATA_W{1'b0}};
      end else begin
         state_r      <= state_s;
         ext_grant_r  <= (state_s == ST_LOAD);
         cpu_ready_r  <= wr_accept_s | rd_capture_s;
         addr_hold_r  <= ram_addr_s;
         wdata_hold_r <= ram_wdata_s;
         if (rd_capture_s) begin
            cpu_rdata_r <= ram_rdata;
         end
         if ((state_s == ST_LOAD) && (state_r != ST_LOAD)) begin
            load_count_r <= {ADDR_W{1'b0}};
         end else if ((state_r == ST_LOAD) && ext_we) begin
            load_count_r <= load_count_r + ADDR_W'(1);
         end
      end
   end

   assign ext_grant  = ext_grant_r;
   assign cpu_ready  = cpu_ready_r;
   assign cpu_rdata  = cpu_rdata_r;
   assign load_count = load_count_r;
   assign ram_we     = ram_we_s;
   assign ram_addr   = ram_addr_s;
   assign ram_wdata  = ram_wdata_s;

endmodule

// File: tb/tb_cnn_mem_port_arbiter.sv
// Directed bench: instance a (RD_LAT=1, 12-bit address) runs a cycle table, instance b
// (RD_LAT=3, 4-bit address) covers drain handover and load_count wrap.
module tb_cnn_mem_port_arbiter;

   localparam bit AUTOINC = `ifdef CNN_LOAD_AUTOINC_EN 1'b1 `else 1'b0 `endif ;
   localparam logic [11:0] RB = AUTOINC ? 12'h002 : 12'h102;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        a_ext_sel, a_ext_we, a_ext_grant, a_cpu_req, a_cpu_we, a_cpu_ready, a_ram_we;
   logic [11:0] a_ext_addr, a_cpu_addr, a_ram_addr, a_load_count;
   logic [15:0] a_ext_wdata, a_cpu_wdata, a_cpu_rdata, a_ram_wdata, a_ram_rdata;

   logic        b_ext_sel, b_ext_we, b_ext_grant, b_cpu_req, b_cpu_we, b_cpu_ready, b_ram_we;
   logic [3:0]  b_ext_addr, b_cpu_addr, b_ram_addr, b_load_count;
   logic [15:0] b_ext_wdata, b_cpu_wdata, b_cpu_rdata, b_ram_wdata, b_ram_rdata;

   logic [15:0] mem_a [0:4095];
   logic [15:0] mem_b [0:15];
   logic [15:0] b_p0, b_p1;

   cnn_mem_port_arbiter #(.DATA_W(16), .ADDR_W(12), .RD_LAT(1)) u_a (
      .clk(clk), .rst(rst),
      .ext_sel(a_ext_sel), .ext_we(a_ext_we), .ext_addr(a_ext_addr), .ext_wdata(a_ext_wdata),
      .ext_grant(a_ext_grant),
      .cpu_req(a_cpu_req), .cpu_we(a_cpu_we), .cpu_addr(a_cpu_addr), .cpu_wdata(a_cpu_wdata),
      .cpu_rdata(a_cpu_rdata), .cpu_ready(a_cpu_ready),
      .ram_we(a_ram_we), .ram_addr(a_ram_addr), .ram_wdata(a_ram_wdata), .ram_rdata(a_ram_rdata),
      .load_count(a_load_count)
   );

   cnn_mem_port_arbiter #(.DATA_W(16), .ADDR_W(4), .RD_LAT(3)) u_b (
      .clk(clk), .rst(rst),
      .ext_sel(b_ext_sel), .ext_we(b_ext_we), .ext_addr(b_ext_addr), .ext_wdata(b_ext_wdata),
      .ext_grant(b_ext_grant),
      .cpu_req(b_cpu_req), .cpu_we(b_cpu_we), .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata),
      .cpu_rdata(b_cpu_rdata), .cpu_ready(b_cpu_ready),
      .ram_we(b_ram_we), .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata), .ram_rdata(b_ram_rdata),
      .load_count(b_load_count)
   );

   // RAM models: a has one read-latency edge, b has three.
   always @(posedge clk) begin
      if (a_ram_we) mem_a[a_ram_addr] <= a_ram_wdata;
      a_ram_rdata <= mem_a[a_ram_addr];
      if (b_ram_we) mem_b[b_ram_addr] <= b_ram_wdata;
      b_p0        <= mem_b[b_ram_addr];
      b_p1        <= b_p0;
      b_ram_rdata <= b_p1;
   end

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   typedef struct packed {
      logic        esel;
      logic        ewe;
      logic [11:0] eaddr;
      logic [15:0] ewd;
      logic        req;
      logic        we;
      logic [11:0] caddr;
      logic [15:0] cwd;
      logic        xwe;
      logic [11:0] xaddr;
      logic [15:0] xwd;
      logic        xrdy;
      logic        xgnt;
      logic [15:0] xrd;
      logic [11:0] xlc;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic esel, input logic ewe, input logic [11:0] eaddr,
                      input logic [15:0] ewd, input logic req, input logic we,
                      input logic [11:0] caddr, input logic [15:0] cwd, input logic xwe,
                      input logic [11:0] xaddr, input logic [15:0] xwd, input logic xrdy,
                      input logic xgnt, input logic [15:0] xrd, input logic [11:0] xlc);
      vec_t v;
      v.esel = esel; v.ewe = ewe; v.eaddr = eaddr; v.ewd = ewd;
      v.req = req; v.we = we; v.caddr = caddr; v.cwd = cwd;
      v.xwe = xwe; v.xaddr = xaddr; v.xwd = xwd; v.xrdy = xrdy;
      v.xgnt = xgnt; v.xrd = xrd; v.xlc = xlc;
      tbl.push_back(v);
   endtask

   function automatic logic [11:0] la(input logic [11:0] n, input logic [11:0] ext);
      return AUTOINC ? n : ext;
   endfunction

   initial begin
      rst = 1'b1;
      a_ext_sel = 1'b0; a_ext_we = 1'b0; a_ext_addr = 12'h000; a_ext_wdata = 16'h0000;
      a_cpu_req = 1'b0; a_cpu_we = 1'b0; a_cpu_addr = 12'h000; a_cpu_wdata = 16'h0000;
      b_ext_sel = 1'b0; b_ext_we = 1'b0; b_ext_addr = 4'h0; b_ext_wdata = 16'h0000;
      b_cpu_req = 1'b0; b_cpu_we = 1'b0; b_cpu_addr = 4'h0; b_cpu_wdata = 16'h0000;

      // esel ewe eaddr ewd | req we caddr cwd | exp: we addr wdata rdy gnt rdata lc
      add(0,0,12'h000,16'h0000, 0,0,12'h000,16'h0000, 0,12'h000,16'h0000, 0,0,16'h0000,12'd0);
      add(0,0,12'h000,16'h0000, 1,1,12'h005,16'hBEEF, 1,12'h005,16'hBEEF, 0,0,16'h0000,12'd0);
      add(0,0,12'h000,16'h0000, 1,1,12'h005,16'hBEEF, 0,12'h005,16'hBEEF, 1,0,16'h0000,12'd0);
      add(0,0,12'h000,16'h0000, 1,0,12'h005,16'h0000, 0,12'h005,16'h0000, 0,0,16'h0000,12'd0);
      add(0,0,12'h000,16'h0000, 1,0,12'h005,16'h0000, 0,12'h005,16'h0000, 0,0,16'h0000,12'd0);
      add(0,0,12'h000,16'h0000, 1,0,12'h005,16'h0000, 0,12'h005,16'h0000, 1,0,16'hBEEF,12'd0);
      add(1,0,12'h000,16'h0000, 1,0,RB,16'h0000, 0,12'h005,16'h0000, 0,0,16'hBEEF,12'd0);
      add(1,1,12'h100,16'h1111, 1,0,RB,16'h0000, 1,la(12'd0,12'h100),16'h1111, 0,1,16'hBEEF,12'd0);
      add(1,1,12'h101,16'h2222, 1,0,RB,16'h0000, 1,la(12'd1,12'h101),16'h2222, 0,1,16'hBEEF,12'd1);
      add(1,1,12'h102,16'h3333, 1,0,RB,16'h0000, 1,la(12'd2,12'h102),16'h3333, 0,1,16'hBEEF,12'd2);
      add(1,1,12'h103,16'h4444, 1,0,RB,16'h0000, 1,la(12'd3,12'h103),16'h4444, 0,1,16'hBEEF,12'd3);
      add(0,0,12'h000,16'h0000, 1,0,RB,16'h0000, 0,la(12'd4,12'h000),16'h0000, 0,1,16'hBEEF,12'd4);
      add(0,0,12'h000,16'h0000, 1,0,RB,16'h0000, 0,la(12'd4,12'h000),16'h0000, 0,0,16'hBEEF,12'd4);
      add(0,0,12'h000,16'h0000, 1,0,RB,16'h0000, 0,RB,16'h0000, 0,0,16'hBEEF,12'd4);
      add(0,0,12'h000,16'h0000, 1,0,RB,16'h0000, 0,RB,16'h0000, 0,0,16'hBEEF,12'd4);
      add(0,0,12'h000,16'h0000, 1,0,RB,16'h0000, 0,RB,16'h0000, 1,0,16'h3333,12'd4);
      add(0,1,12'h005,16'hDEAD, 0,0,12'h000,16'h0000, 0,RB,16'h0000, 0,0,16'h3333,12'd4);

      repeat (3) @(posedge clk);
      #1;
      chk("rst_a_ready", 32'(a_cpu_ready), 32'd0);
      chk("rst_a_grant", 32'(a_ext_grant), 32'd0);
      chk("rst_a_rdata", 32'(a_cpu_rdata), 32'd0);
      chk("rst_a_lc",    32'(a_load_count), 32'd0);
      chk("rst_b_ready", 32'(b_cpu_ready), 32'd0);
      chk("rst_b_grant", 32'(b_ext_grant), 32'd0);
      rst = 1'b0;

      for (int i = 0; i < tbl.size(); i++) begin
         a_ext_sel = tbl[i].esel; a_ext_we = tbl[i].ewe;
         a_ext_addr = tbl[i].eaddr; a_ext_wdata = tbl[i].ewd;
         a_cpu_req = tbl[i].req; a_cpu_we = tbl[i].we;
         a_cpu_addr = tbl[i].caddr; a_cpu_wdata = tbl[i].cwd;
         @(negedge clk);
         chk($sformatf("v%0d_ram_we", i),    32'(a_ram_we),     32'(tbl[i].xwe));
         chk($sformatf("v%0d_ram_addr", i),  32'(a_ram_addr),   32'(tbl[i].xaddr));
         chk($sformatf("v%0d_ram_wdata", i), 32'(a_ram_wdata),  32'(tbl[i].xwd));
         chk($sformatf("v%0d_ready", i),     32'(a_cpu_ready),  32'(tbl[i].xrdy));
         chk($sformatf("v%0d_grant", i),     32'(a_ext_grant),  32'(tbl[i].xgnt));
         chk($sformatf("v%0d_rdata", i),     32'(a_cpu_rdata),  32'(tbl[i].xrd));
         chk($sformatf("v%0d_lc", i),        32'(a_load_count), 32'(tbl[i].xlc));
         @(posedge clk);
         #1;
      end

      // Reset one cycle after a read is accepted.
      a_ext_sel = 1'b0; a_ext_we = 1'b0; a_ext_addr = 12'h000; a_ext_wdata = 16'h0000;
      a_cpu_req = 1'b1; a_cpu_we = 1'b0; a_cpu_addr = 12'h010; a_cpu_wdata = 16'h0000;
      @(posedge clk);
      #1;
      rst = 1'b1;
      a_cpu_req = 1'b0;
      #1;
      chk("mid_rst_ready",    32'(a_cpu_ready),  32'd0);
      chk("mid_rst_grant",    32'(a_ext_grant),  32'd0);
      chk("mid_rst_rdata",    32'(a_cpu_rdata),  32'd0);
      chk("mid_rst_lc",       32'(a_load_count), 32'd0);
      chk("mid_rst_ram_we",   32'(a_ram_we),     32'd0);
      chk("mid_rst_ram_addr", 32'(a_ram_addr),   32'd0);
      chk("mid_rst_ram_wd",   32'(a_ram_wdata),  32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk($sformatf("post_rst_ready_%0d", k), 32'(a_cpu_ready), 32'd0);
      end
      @(posedge clk);
      #1;

      // Instance b: read at t, loader request from t+1, drain until ready at t+4.
      b_cpu_req = 1'b1; b_cpu_we = 1'b0; b_cpu_addr = 4'h3;
      @(negedge clk);
      chk("b_rd_addr", 32'(b_ram_addr), 32'h3);
      chk("b_rd_we",   32'(b_ram_we),   32'd0);
      @(posedge clk);
      #1;
      b_ext_sel = 1'b1; b_ext_we = 1'b1; b_ext_addr = 4'hA; b_ext_wdata = 16'h5555;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         chk($sformatf("b_drain_we_%0d", k),    32'(b_ram_we),    32'd0);
         chk($sformatf("b_drain_ready_%0d", k), 32'(b_cpu_ready), 32'(k == 4));
         chk($sformatf("b_drain_grant_%0d", k), 32'(b_ext_grant), 32'd0);
         @(posedge clk);
         #1;
      end
      b_cpu_req = 1'b0;
      for (int w = 0; w < 17; w++) begin
         b_ext_wdata = 16'h5000 + 16'(w);
         @(negedge clk);
         chk($sformatf("b_load_grant_%0d", w), 32'(b_ext_grant),  32'd1);
         chk($sformatf("b_load_we_%0d", w),    32'(b_ram_we),     32'd1);
         chk($sformatf("b_load_addr_%0d", w),  32'(b_ram_addr),   AUTOINC ? 32'(w % 16) : 32'hA);
         chk($sformatf("b_load_lc_%0d", w),    32'(b_load_count), 32'(w % 16));
         @(posedge clk);
         #1;
      end
      b_ext_sel = 1'b0; b_ext_we = 1'b0;
      @(negedge clk);
      chk("b_lc_wrap", 32'(b_load_count), 32'd1);
      chk("b_last_we", 32'(b_ram_we),     32'd0);
      chk("b_mem_17th", 32'(mem_b[AUTOINC ? 0 : 10]), 32'h5010);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("b_handback_grant", 32'(b_ext_grant),  32'd0);
      chk("b_handback_lc",    32'(b_load_count), 32'd1);
      @(posedge clk);
      #1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
